pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic, parametrised inter-stage pipeline register (IF/ID ... MEM/WB successor).
//  Carries one opaque payload word per beat with valid/ready handshake, flush, and an
//  optional 2-entry skid buffer so ready is fully registered. Control bits of bubbles
//  are forced to zero. Sits between any two CPU stages; MEM/WB is the first user.
// PARAMETERS
//  DATA_W   106  payload width in bits (MEM/WB packs outA, outB, PC, MemtoReg, RegDst, WrReg, RegWr)
//  CTL_W    1    number of payload LSBs that are control (e.g. RegWr); zeroed in bubbles; 0..DATA_W
//  SKID     1    1 = 2-entry skid buffer with registered in_ready; 0 = single-entry stall register
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous squash of all held beats
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       beat presented downstream
//  out_ready  in   1       downstream accepts this cycle
//  out_data   out  DATA_W  payload of head entry
//  occ        out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - accept = in_valid & in_ready; pop = out_valid & out_ready. One beat/cycle max each way.
//  - Reset: out_valid=0, out_data=0, occ=0, in_ready=1 (SKID=1) / 1 (SKID=0, empty).
//    Handshakes in a reset cycle are ignored; reset dominates flush.
//  - Priority per edge: reset > flush > normal transfer.
//  - SKID=1 states (main, skid entries): EMPTY, ONE, FULL.
//      EMPTY: accept -> ONE, main<=in_data.
//      ONE  : accept&pop -> ONE, main<=in_data; accept&!pop -> FULL, skid<=in_data;
//             !accept&pop -> EMPTY; else hold.
//      FULL : pop -> ONE, main<=skid; else hold. accept impossible (in_ready=0).
//      in_ready is a flop = (next state != FULL); no combinational out_ready->in_ready path.
//  - SKID=0: single entry; in_ready = !out_valid | out_ready (combinational).
//      accept -> main<=in_data, valid=1; pop&!accept -> valid=0.
//  - Latency: accepted beat appears on out_valid the next cycle when stage was EMPTY, or
//    ONE with pop. Sustained throughput 1 beat/cycle with out_ready held 1.
//  - Bubble rule: whenever main becomes/stays invalid, out_data[CTL_W-1:0] is 0 at the
//    flop; data bits above CTL_W may hold stale values. out_data is registered.
//  - flush: next cycle state EMPTY, out_valid=0, ctl bits 0, occ=0, in_ready=1. Beat
//    offered on in_* during flush is dropped (in_ready still reported as usual that cycle);
//    a pop in the flush cycle is a completed transfer.
//  - FULL + flush + out_ready=0: both entries discarded, no beat ever emerges.
//  - occ = main_valid + skid_valid; never 3; skid never valid while main invalid.
//  - Payload order strictly FIFO; no reordering, no duplication, no loss except via flush.
// STRUCTURE
//  - Package pipe_pkg: typedef enum {EMPTY, ONE, FULL} pipe_st_t; MEMWB_W=106 and
//    MEMWB field offset/width localparams (OUTA, OUTB, PC, MEMTOREG, REGDST, WRREG, REGWR@bit0)
//    shared by MEM and WB stage pack/unpack logic.
//  - Single module; no sub-module. SKID selected by generate block.
// TESTING
//  1 Reset: hold reset 3 cycles with in_valid=1, in_data=0x1 -> out_valid=0, out_data=0,
//    occ=0, in_ready=1; first accept after deassert appears 1 cycle later.
//  2 Streaming (SKID=1): out_ready=1, beats 0xA0..0xA7 back-to-back -> same sequence on
//    out_data, one per cycle, latency 1, occ stays 1.
//  3 Backpressure: out_ready=0, send 0xB0,0xB1,0xB2 -> 0xB0,0xB1 held (occ=2), in_ready=0
//    next cycle, 0xB2 not accepted; raise out_ready -> 0xB0,0xB1,0xB2 in order, no gap.
//  4 Flush when FULL, out_ready=0, in_valid=1 data 0xC5 -> next cycle out_valid=0, occ=0,
//    out_data[0]=0, in_ready=1; 0xC5 never emerges.
//  5 Bubble ctl: single beat with RegWr bit=1, then idle -> after pop out_valid=0 and
//    out_data[0]=0.
//  6 SKID=0: out_ready toggling 1,0,1 with continuous input -> in_ready follows
//    !out_valid|out_ready same cycle, no beat lost or duplicated.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-register types and the MEM/WB payload layout.
// Used by MEM-stage packing, WB-stage unpacking and pipe_stage_reg.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_st_t;

  localparam int MEMWB_W = 106;

  localparam int REGWR_O    = 0;
  localparam int REGWR_W    = 1;
  localparam int WRREG_O    = 1;
  localparam int WRREG_W    = 5;
  localparam int REGDST_O   = 6;
  localparam int REGDST_W   = 2;
  localparam int MEMTOREG_O = 8;
  localparam int MEMTOREG_W = 2;
  localparam int PC_O       = 10;
  localparam int PC_W       = 32;
  localparam int OUTB_O     = 42;
  localparam int OUTB_W     = 32;
  localparam int OUTA_O     = 74;
  localparam int OUTA_W     = 32;

  function automatic logic [MEMWB_W-1:0] memwb_pack(
    input logic [OUTA_W-1:0]     outa,
    input logic [OUTB_W-1:0]     outb,
    input logic [PC_W-1:0]       pc,
    input logic [MEMTOREG_W-1:0] m2r,
    input logic [REGDST_W-1:0]   rdst,
    input logic [WRREG_W-1:0]    wrreg,
    input logic [REGWR_W-1:0]    regwr
  );
    logic [MEMWB_W-1:0] w;
    w = '0;
    w[OUTA_O     +: OUTA_W]     = outa;
    w[OUTB_O     +: OUTB_W]     = outb;
    w[PC_O       +: PC_W]       = pc;
    w[MEMTOREG_O +: MEMTOREG_W] = m2r;
    w[REGDST_O   +: REGDST_W]   = rdst;
    w[WRREG_O    +: WRREG_W]    = wrreg;
    w[REGWR_O    +: REGWR_W]    = regwr;
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready and flush.
// SKID=1 gives a 2-entry skid with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_W,
  parameter int CTL_W  = REGWR_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  localparam logic [DATA_W-1:0] CTL_MASK =
    ~({DATA_W{1'b1}} << CTL_W);

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  generate
    if (SKID) begin : g_skid
      pipe_st_t          st_q, st_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              rdy_q;

      always_comb begin
        st_d   = st_q;
        main_d = main_q;
        skid_d = skid_q;
        unique case (st_q)
          EMPTY: begin
            if (accept) begin
              st_d   = ONE;
              main_d = in_data;
            end
          end
          ONE: begin
            if (accept && pop) begin
              main_d = in_data;
            end else if (accept) begin
              st_d   = FULL;
              skid_d = in_data;
            end else if (pop) begin
              st_d = EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              st_d   = ONE;
              main_d = skid_q;
            end
          end
          default: st_d = EMPTY;
        endcase
        if (flush) st_d = EMPTY;
        // bubbles never carry live control bits
        if (st_d == EMPTY) main_d = main_d & ~CTL_MASK;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          st_q   <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
          rdy_q  <= 1'b1;
        end else begin
          st_q   <= st_d;
          main_q <= main_d;
          skid_q <= skid_d;
          rdy_q  <= (st_d != FULL);
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (st_q != EMPTY);
      assign out_data  = main_q;
      assign occ       = {st_q == FULL, st_q == ONE};
    end else begin : g_single
      logic              vld_q, vld_d;
      logic [DATA_W-1:0] main_q, main_d;

      always_comb begin
        vld_d  = vld_q;
        main_d = main_q;
        if (accept) begin
          vld_d  = 1'b1;
          main_d = in_data;
        end else if (pop) begin
          vld_d = 1'b0;
        end
        if (flush) vld_d = 1'b0;
        if (!vld_d) main_d = main_d & ~CTL_MASK;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= 1'b0;
          main_q <= '0;
        end else begin
          vld_q  <= vld_d;
          main_q <= main_d;
        end
      end

      assign in_ready  = !vld_q | out_ready;
      assign out_valid = vld_q;
      assign out_data  = main_q;
      assign occ       = {1'b0, vld_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances driven
// in lockstep and checked against bounded-FIFO reference models.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = MEMWB_W;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         rdy1, vld1, rdy0, vld0;
  logic [W-1:0] dat1, dat0;
  logic [1:0]   occ1, occ0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m1[$];
  logic [W-1:0] m0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .CTL_W(1), .SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
    .occ(occ1)
  );

  pipe_stage_reg #(.DATA_W(W), .CTL_W(1), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
    .occ(occ0)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_state;
    chk("s1_rdy", 128'(rdy1), 128'(m1.size() != 2));
    chk("s1_vld", 128'(vld1), 128'(m1.size() > 0));
    chk("s1_occ", 128'(occ1), 128'(m1.size()));
    if (m1.size() > 0) chk("s1_data", 128'(dat1), 128'(m1[0]));
    else chk("s1_ctl", 128'(dat1[0]), 128'(0));
    chk("s0_rdy", 128'(rdy0), 128'(m0.size() == 0 || out_ready));
    chk("s0_vld", 128'(vld0), 128'(m0.size() > 0));
    chk("s0_occ", 128'(occ0), 128'(m0.size()));
    if (m0.size() > 0) chk("s0_data", 128'(dat0), 128'(m0[0]));
    else chk("s0_ctl", 128'(dat0[0]), 128'(0));
  endtask

  task automatic cyc(input logic rst, input logic fl,
                     input logic iv, input logic [W-1:0] d,
                     input logic ordy);
    bit acc1, pop1, acc0, pop0;
    reset = rst; flush = fl; in_valid = iv;
    in_data = d; out_ready = ordy;
    #1;
    chk_state();
    acc1 = iv && (m1.size() != 2);
    pop1 = (m1.size() > 0) && ordy;
    acc0 = iv && (m0.size() == 0 || ordy);
    pop0 = (m0.size() > 0) && ordy;
    @(posedge clk);
    if (rst || fl) begin
      m1.delete();
      m0.delete();
    end else begin
      if (pop1) void'(m1.pop_front());
      if (acc1) m1.push_back(d);
      if (pop0) void'(m0.pop_front());
      if (acc0) m0.push_back(d);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: reset held with a beat offered, then first accept
    repeat (3) cyc(1'b1, 1'b0, 1'b1, W'(1), 1'b1);
    #1;
    chk("rst_data1", 128'(dat1), 128'(0));
    chk("rst_data0", 128'(dat0), 128'(0));
    cyc(1'b1, 1'b1, 1'b1, W'(1), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, W'(1), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // 2: streaming
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, 1'b1, W'(8'hA0 + i), 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // 3: backpressure
    cyc(1'b0, 1'b0, 1'b1, W'(8'hB0), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, W'(8'hB1), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, W'(8'hB2), 1'b0);
    #1;
    chk("bp_occ", 128'(occ1), 128'(2));
    chk("bp_rdy", 128'(rdy1), 128'(0));
    cyc(1'b0, 1'b0, 1'b1, W'(8'hB2), 1'b1);
    cyc(1'b0, 1'b0, 1'b1, W'(8'hB2), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // 4: flush while full and stalled
    cyc(1'b0, 1'b0, 1'b1, W'(8'hC1), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, W'(8'hC3), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, W'(8'hC5), 1'b0);
    #1;
    chk("fl_vld", 128'(vld1), 128'(0));
    chk("fl_occ", 128'(occ1), 128'(0));
    chk("fl_rdy", 128'(rdy1), 128'(1));
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // 5: bubble control bits cleared after the pop
    cyc(1'b0, 1'b0, 1'b1,
        memwb_pack(32'h1234_5678, 32'h9abc_def0, 32'h400,
                   2'd1, 2'd2, 5'd7, 1'b1), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("bub_vld", 128'(vld1), 128'(0));
    chk("bub_ctl", 128'(dat1[0]), 128'(0));
    chk("bub_ctl0", 128'(dat0[0]), 128'(0));

    // 6: toggling out_ready with continuous input
    for (int i = 0; i < 12; i++)
      cyc(1'b0, 1'b0, 1'b1, W'(8'hD0 + i), 1'((i % 3) != 1));
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // random traffic with odd-ctl payloads and occasional flush
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 3) != 0),
          rnd() | W'(1),
          1'($urandom_range(0, 2) != 0));
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
